// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin, burst-locked sharing of one FIFO write port.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_din,
  output logic [NUM_PORTS-1:0]            ack,
  input  logic                            full,
  output logic                            wr,
  output logic [DATA_WIDTH-1:0]           din
);

  localparam int              OW     = $clog2(NUM_PORTS);
  localparam int              CW     = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   C_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);
  localparam logic [OW-1:0]   C_LAST = OW'(NUM_PORTS - 1);

  logic [OW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic                  r_locked;

  logic                  w_hold;
  logic                  w_valid;
  logic [OW-1:0]         w_grant;
  int                    w_best;
  logic [DATA_WIDTH-1:0] w_data [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign w_data[i] = req_din[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Owner keeps the port while its burst has room; otherwise the nearest
  // requester after the owner wins, with the owner itself searched last.
  always_comb begin
    w_hold  = r_locked && req[r_owner] && (r_cnt < C_MAX);
    w_valid = 1'b0;
    w_grant = r_owner;
    w_best  = NUM_PORTS;
    if (!full && (req != '0)) begin
      w_valid = 1'b1;
      if (!w_hold) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (req[i] && (((i - int'(r_owner) - 1 + NUM_PORTS) % NUM_PORTS) < w_best)) begin
            w_best  = (i - int'(r_owner) - 1 + NUM_PORTS) % NUM_PORTS;
            w_grant = OW'(i);
          end
        end
      end
    end
  end

  assign wr  = w_valid & rst;
  assign din = w_data[w_valid ? w_grant : r_owner];

  always_comb begin
    ack = '0;
    if (wr) ack[w_grant] = 1'b1;
  end

  // An idle, non-full cycle with the owner not requesting releases the lock,
  // so a returning owner competes in the rotation instead of resuming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= C_LAST;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (w_valid) begin
      if (w_hold) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_owner  <= w_grant;
        r_cnt    <= C_ONE;
        r_locked <= 1'b1;
      end
    end else if (!full && r_locked && !req[r_owner]) begin
      r_locked <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed bench with a behavioural grant model for two burst sizes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        full;
  logic [127:0] req_din;
  logic [3:0]  ack_a, ack_b;
  logic        wr_a, wr_b;
  logic [31:0] din_a, din_b;
  logic [31:0] data_v [4];

  int tests_run = 0;
  int tests_failed = 0;

  int m_own [2];
  int m_used [2];
  bit m_lk [2];
  int log_a [$];
  int log_b [$];

  fifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(4), .MAX_BURST(4)) u_a (
    .clk(clk), .rst(rst), .req(req), .req_din(req_din),
    .ack(ack_a), .full(full), .wr(wr_a), .din(din_a)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(4), .MAX_BURST(1)) u_b (
    .clk(clk), .rst(rst), .req(req), .req_din(req_din),
    .ack(ack_b), .full(full), .wr(wr_b), .din(din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int own, input int used,
                              input bit lk, input int mb);
    int p;
    if (r == 4'b0) return -1;
    p = own;
    if (lk && r[p[1:0]] && used < mb) return own;
    for (int k = 1; k <= 4; k++) begin
      p = (own + k) % 4;
      if (r[p[1:0]]) return p;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] a);
    case (a)
      4'b0000: return -1;
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -2;
    endcase
  endfunction

  // Model: per cycle, work out the grant from the request/burst rules.
  always @(negedge clk) begin
    logic [3:0]  a_v;
    logic        w_v;
    logic [31:0] d_v;
    logic [3:0]  ea;
    int          g;
    int          o;
    int          mb;
    for (int d = 0; d < 2; d++) begin
      a_v = (d == 0) ? ack_a : ack_b;
      w_v = (d == 0) ? wr_a  : wr_b;
      d_v = (d == 0) ? din_a : din_b;
      mb  = (d == 0) ? 4 : 1;
      if (!rst) begin
        chk(d == 0 ? "a_rst_wr" : "b_rst_wr", 32'(w_v), 32'd0);
        chk(d == 0 ? "a_rst_ack" : "b_rst_ack", 32'(a_v), 32'd0);
        m_own[d]  = 3;
        m_used[d] = 0;
        m_lk[d]   = 1'b0;
      end else begin
        g  = full ? -1 : pick(req, m_own[d], m_used[d], m_lk[d], mb);
        ea = (g >= 0) ? 4'(32'd1 << g) : 4'd0;
        chk(d == 0 ? "a_wr" : "b_wr", 32'(w_v), 32'(g >= 0));
        chk(d == 0 ? "a_ack" : "b_ack", 32'(a_v), 32'(ea));
        if (g >= 0) chk(d == 0 ? "a_din" : "b_din", d_v, data_v[g[1:0]]);
        if (d == 0) log_a.push_back(onehot_idx(a_v));
        else        log_b.push_back(onehot_idx(a_v));
        o = m_own[d];
        if (g >= 0) begin
          if (m_lk[d] && g == m_own[d] && m_used[d] < mb) begin
            m_used[d] = m_used[d] + 1;
          end else begin
            m_own[d]  = g;
            m_used[d] = 1;
            m_lk[d]   = 1'b1;
          end
        end else if (!full && m_lk[d] && !req[o[1:0]]) begin
          m_lk[d] = 1'b0;
        end
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic f, input logic rs);
    @(posedge clk);
    #1;
    req  = r;
    full = f;
    rst  = rs;
  endtask

  task automatic set_data(input int tag);
    for (int i = 0; i < 4; i++) data_v[i] = 32'hC0DE_0000 | 32'(tag << 8) | 32'(i);
    req_din = {data_v[3], data_v[2], data_v[1], data_v[0]};
  endtask

  // Expected grant sequence as hex nibbles, left to right; F means no grant.
  task automatic chk_log(input string nm, input int q[$], input logic [127:0] exp, input int n);
    logic [3:0] e;
    logic [3:0] act;
    chk({nm, "_len"}, 32'(q.size()), 32'(n));
    for (int k = 0; k < n && k < q.size(); k++) begin
      e   = exp[4*(n-1-k) +: 4];
      act = (q[k] == -1) ? 4'hF : (q[k] < 0) ? 4'hE : 4'(q[k]);
      chk($sformatf("%s_%0d", nm, k), 32'(act), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b0; full = 1'b0;
    set_data(0);
    #1 rst = 1'b0;
    req = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_wr", 32'(wr_a), 32'd0);
    chk("reset_ack", 32'(ack_a), 32'd0);

    // All four requesting: bursts of four rotating from port 0.
    step(4'hF, 1'b0, 1'b1); set_data(1); log_a.delete(); log_b.delete();
    #2;
    chk("t1_first_ack", 32'(ack_a), 32'h1);
    chk("t1_first_din", din_a, 32'hC0DE_0100);
    repeat (19) step(4'hF, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk_log("t1_a", log_a, 128'h0000_1111_2222_3333_0000, 20);
    chk_log("t1_b", log_b, 128'h0123_0123_0123_0123_0123, 20);

    // Lone requester: no bubbles across burst boundaries.
    step(4'h0, 1'b0, 1'b1);
    step(4'h4, 1'b0, 1'b1); set_data(2); log_a.delete(); log_b.delete();
    repeat (9) step(4'h4, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk_log("t2_a", log_a, 128'h22222_22222, 10);
    chk_log("t2_b", log_b, 128'h22222_22222, 10);

    // full freezes a burst at count 2.
    step(4'h0, 1'b0, 1'b1);
    step(4'h3, 1'b0, 1'b1); set_data(3); log_a.delete(); log_b.delete();
    step(4'h3, 1'b0, 1'b1);
    repeat (3) step(4'h3, 1'b1, 1'b1);
    repeat (4) step(4'h3, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk_log("t3_a", log_a, 128'h00FFF0011, 9);
    chk_log("t3_b", log_b, 128'h01FFF0101, 9);

    // Owner drop hands over to port 3 at once; port 1 then waits its burst.
    step(4'h0, 1'b0, 1'b1);
    step(4'h1, 1'b0, 1'b1); set_data(4); log_a.delete(); log_b.delete();
    step(4'hA, 1'b0, 1'b1);
    step(4'hA, 1'b0, 1'b1);
    step(4'h8, 1'b0, 1'b1);
    repeat (5) step(4'hA, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk_log("t4_a", log_a, 128'h011333311, 9);
    chk_log("t4_b", log_b, 128'h013313131, 9);

    // Fresh reset, two requesters at opposite ends.
    step(4'h0, 1'b0, 1'b0);
    step(4'h9, 1'b0, 1'b1); set_data(5); log_a.delete(); log_b.delete();
    repeat (5) step(4'h9, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk_log("t5_a", log_a, 128'h000033, 6);
    chk_log("t5_b", log_b, 128'h030303, 6);

    // Asynchronous reset in the middle of port 3's second write.
    step(4'h0, 1'b0, 1'b1);
    step(4'h8, 1'b0, 1'b1);
    step(4'h8, 1'b0, 1'b1);
    #2;
    chk("t6_pre_wr", 32'(wr_a), 32'd1);
    chk("t6_pre_ack", 32'(ack_a), 32'h8);
    rst = 1'b0;
    #1;
    chk("t6_async_wr", 32'(wr_a), 32'd0);
    chk("t6_async_ack", 32'(ack_a), 32'd0);
    chk("t6_async_wr_b", 32'(wr_b), 32'd0);
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1); set_data(6); log_a.delete(); log_b.delete();
    repeat (3) step(4'hF, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk_log("t6_a", log_a, 128'h0000, 4);
    chk_log("t6_b", log_b, 128'h0123, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
